// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: op encoding, widths, entry and bus payloads.
package alu_rs_pkg;

    localparam int unsigned RS_SIZE   = 16;
    localparam int unsigned RS_WIDTH  = 4;
    localparam int unsigned ROB_WIDTH = 4;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned OP_WIDTH  = 5;

    typedef logic [XLEN-1:0]      data_t;
    typedef logic [XLEN-1:0]      addr_t;
    typedef logic [ROB_WIDTH-1:0] rob_tag_t;
    typedef logic [RS_WIDTH-1:0]  rs_idx_t;

    // OP_ENUM_RESET doubles as the "nothing dispatched" marker and must stay at zero.
    typedef enum logic [OP_WIDTH-1:0] {
        OP_ENUM_RESET = 5'd0,
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_ADDI,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
    } op_enum_t;

    typedef struct packed {
        logic     q_valid;
        rob_tag_t q;
        data_t    v;
    } operand_t;

    typedef struct packed {
        logic     valid;
        rob_tag_t tag;
        data_t    value;
    } cdb_t;

    typedef struct packed {
        op_enum_t op;
        operand_t src1;
        operand_t src2;
        data_t    imm;
        addr_t    pc;
        rob_tag_t rob;
    } rs_entry_t;

    typedef struct packed {
        op_enum_t op;
        data_t    v1;
        data_t    v2;
        data_t    imm;
        addr_t    pc;
        rob_tag_t rob;
    } alu_req_t;

    typedef struct packed {
        logic     valid;
        rob_tag_t rob;
        data_t    value;
        addr_t    target;
        logic     jump;
    } alu_res_t;

    // Resolve a pending operand from either broadcast; the ALU bus wins a double match.
    function automatic operand_t snoop(operand_t cur, cdb_t alu, cdb_t lsb);
        operand_t r;
        r = cur;
        if (cur.q_valid) begin
            if (alu.valid && alu.tag == cur.q) begin
                r.v       = alu.value;
                r.q_valid = 1'b0;
            end else if (lsb.valid && lsb.tag == cur.q) begin
                r.v       = lsb.value;
                r.q_valid = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Issue, CDB snoop, ALU dispatch and ALU-CDB result signals of the ALU reservation station.
interface alu_rs_if;
    import alu_rs_pkg::*;

    logic     issue_valid_in;
    op_enum_t issue_op_in;
    data_t    issue_V1_in;
    data_t    issue_V2_in;
    logic     issue_Q1_valid_in;
    logic     issue_Q2_valid_in;
    rob_tag_t issue_Q1_in;
    rob_tag_t issue_Q2_in;
    data_t    issue_imm_in;
    addr_t    issue_pc_in;
    rob_tag_t issue_rob_in;
    logic     full_out;

    logic     cdb_alu_valid_in;
    rob_tag_t cdb_alu_tag_in;
    data_t    cdb_alu_value_in;
    logic     cdb_lsb_valid_in;
    rob_tag_t cdb_lsb_tag_in;
    data_t    cdb_lsb_value_in;

    op_enum_t alu_op_out;
    data_t    alu_V1_out;
    data_t    alu_V2_out;
    data_t    alu_imm_out;
    addr_t    alu_pc_out;
    data_t    alu_result_in;
    logic     alu_jump_in;
    addr_t    alu_target_in;

    logic     result_valid_out;
    rob_tag_t result_rob_out;
    data_t    result_value_out;
    addr_t    result_target_out;
    logic     result_jump_out;

    modport slave (
        input  issue_valid_in, issue_op_in, issue_V1_in, issue_V2_in,
               issue_Q1_valid_in, issue_Q2_valid_in, issue_Q1_in, issue_Q2_in,
               issue_imm_in, issue_pc_in, issue_rob_in,
               cdb_alu_valid_in, cdb_alu_tag_in, cdb_alu_value_in,
               cdb_lsb_valid_in, cdb_lsb_tag_in, cdb_lsb_value_in,
               alu_result_in, alu_jump_in, alu_target_in,
        output full_out, alu_op_out, alu_V1_out, alu_V2_out, alu_imm_out, alu_pc_out,
               result_valid_out, result_rob_out, result_value_out,
               result_target_out, result_jump_out
    );

    modport master (
        output issue_valid_in, issue_op_in, issue_V1_in, issue_V2_in,
               issue_Q1_valid_in, issue_Q2_valid_in, issue_Q1_in, issue_Q2_in,
               issue_imm_in, issue_pc_in, issue_rob_in,
               cdb_alu_valid_in, cdb_alu_tag_in, cdb_alu_value_in,
               cdb_lsb_valid_in, cdb_lsb_tag_in, cdb_lsb_value_in,
               alu_result_in, alu_jump_in, alu_target_in,
        input  full_out, alu_op_out, alu_V1_out, alu_V2_out, alu_imm_out, alu_pc_out,
               result_valid_out, result_rob_out, result_value_out,
               result_target_out, result_jump_out
    );

endinterface

// File: rtl/alu_rs_select.sv
// Lowest-index priority encoder: reports whether any request bit is set and which one.
module alu_rs_select #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] req,
    output logic         found_c,
    output logic [W-1:0] idx_c
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                found_c = 1'b1;
                idx_c   = W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers issued ops, snoops both CDBs, dispatches the lowest
// ready entry per cycle into registered ALU operands and registers the ALU result.
module alu_rs
    import alu_rs_pkg::*;
(
    input  logic     clk_in,
    input  logic     rst_n_in,
    input  logic     rdy_in,
    input  logic     clear_in,
    alu_rs_if.slave  bus
);

    logic [RS_SIZE-1:0] busy_q;
    logic [RS_SIZE-1:0] busy_d;
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    rs_entry_t          ent_q [RS_SIZE];
    rs_entry_t          ent_d [RS_SIZE];
    alu_req_t           req_q;
    alu_req_t           req_d;
    alu_res_t           res_q;
    alu_res_t           res_d;
    rs_entry_t          new_ent;
    operand_t           iss1;
    operand_t           iss2;
    cdb_t               cdb_alu;
    cdb_t               cdb_lsb;
    logic               free_found;
    logic               ready_found;
    rs_idx_t            free_idx;
    rs_idx_t            ready_idx;

    assign cdb_alu = '{valid: bus.cdb_alu_valid_in, tag: bus.cdb_alu_tag_in,
                       value: bus.cdb_alu_value_in};
    assign cdb_lsb = '{valid: bus.cdb_lsb_valid_in, tag: bus.cdb_lsb_tag_in,
                       value: bus.cdb_lsb_value_in};

    // Ready is judged on registered state only, so a fresh wake-up waits one cycle.
    always_comb begin
        free_vec  = ~busy_q;
        ready_vec = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            ready_vec[i] = busy_q[i] & ~ent_q[i].src1.q_valid & ~ent_q[i].src2.q_valid;
        end
    end

    alu_rs_select #(.N(RS_SIZE), .W(RS_WIDTH)) u_free_sel (
        .req     (free_vec),
        .found_c (free_found),
        .idx_c   (free_idx)
    );

    alu_rs_select #(.N(RS_SIZE), .W(RS_WIDTH)) u_ready_sel (
        .req     (ready_vec),
        .found_c (ready_found),
        .idx_c   (ready_idx)
    );

    // Incoming entry, with operands already captured if a CDB carries them this cycle.
    always_comb begin
        iss1         = '{q_valid: bus.issue_Q1_valid_in, q: bus.issue_Q1_in, v: bus.issue_V1_in};
        iss2         = '{q_valid: bus.issue_Q2_valid_in, q: bus.issue_Q2_in, v: bus.issue_V2_in};
        new_ent      = '0;
        new_ent.op   = bus.issue_op_in;
        new_ent.src1 = snoop(iss1, cdb_alu, cdb_lsb);
        new_ent.src2 = snoop(iss2, cdb_alu, cdb_lsb);
        new_ent.imm  = bus.issue_imm_in;
        new_ent.pc   = bus.issue_pc_in;
        new_ent.rob  = bus.issue_rob_in;
    end

    // Next state: flush beats everything; otherwise result, wake-up, dispatch and issue together.
    always_comb begin
        busy_d = busy_q;
        ent_d  = ent_q;
        req_d  = req_q;
        res_d  = res_q;
        if (rdy_in) begin
            if (clear_in) begin
                busy_d      = '0;
                req_d.op    = OP_ENUM_RESET;
                res_d.valid = 1'b0;
            end else begin
                res_d.valid  = (req_q.op != OP_ENUM_RESET);
                res_d.rob    = req_q.rob;
                res_d.value  = bus.alu_result_in;
                res_d.target = bus.alu_target_in;
                res_d.jump   = bus.alu_jump_in;

                for (int i = 0; i < int'(RS_SIZE); i++) begin
                    if (busy_q[i]) begin
                        ent_d[i].src1 = snoop(ent_q[i].src1, cdb_alu, cdb_lsb);
                        ent_d[i].src2 = snoop(ent_q[i].src2, cdb_alu, cdb_lsb);
                    end
                end

                if (ready_found) begin
                    req_d.op          = ent_q[ready_idx].op;
                    req_d.v1          = ent_q[ready_idx].src1.v;
                    req_d.v2          = ent_q[ready_idx].src2.v;
                    req_d.imm         = ent_q[ready_idx].imm;
                    req_d.pc          = ent_q[ready_idx].pc;
                    req_d.rob         = ent_q[ready_idx].rob;
                    busy_d[ready_idx] = 1'b0;
                end else begin
                    req_d.op = OP_ENUM_RESET;
                end

                // An issue while full finds no free slot and is dropped.
                if (bus.issue_valid_in && free_found) begin
                    busy_d[free_idx] = 1'b1;
                    ent_d[free_idx]  = new_ent;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q <= '0;
            ent_q  <= '{default: '0};
            req_q  <= '0;
            res_q  <= '0;
        end else begin
            busy_q <= busy_d;
            ent_q  <= ent_d;
            req_q  <= req_d;
            res_q  <= res_d;
        end
    end

    assign bus.full_out          = &busy_q;
    assign bus.alu_op_out        = req_q.op;
    assign bus.alu_V1_out        = req_q.v1;
    assign bus.alu_V2_out        = req_q.v2;
    assign bus.alu_imm_out       = req_q.imm;
    assign bus.alu_pc_out        = req_q.pc;
    assign bus.result_valid_out  = res_q.valid;
    assign bus.result_rob_out    = res_q.rob;
    assign bus.result_value_out  = res_q.value;
    assign bus.result_target_out = res_q.target;
    assign bus.result_jump_out   = res_q.jump;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_rs;
    import alu_rs_pkg::*;

    typedef logic [203:0] snap_t;

    typedef struct {
        bit          busy;
        op_enum_t    op;
        bit          p1;
        bit          p2;
        logic [3:0]  t1;
        logic [3:0]  t2;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
    } m_ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic rdy   = 1'b1;
    logic clr   = 1'b0;
    int   tests = 0;
    int   fails = 0;

    alu_rs_if bus();

    alu_rs dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .clear_in (clr),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Model of the external ALU: {jump, target, result}.
    function automatic logic [64:0] alu_fn(op_enum_t op, logic [31:0] a, logic [31:0] b,
                                           logic [31:0] imm, logic [31:0] pc);
        logic        j;
        logic [31:0] t;
        logic [31:0] r;
        j = 1'b0;
        t = pc + 32'd4;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_ADDI: r = a + imm;
            OP_BEQ:  begin j = (a == b); t = pc + imm; end
            OP_BNE:  begin j = (a != b); t = pc + imm; end
            OP_JAL:  begin j = 1'b1; t = pc + imm; r = pc + 32'd4; end
            default: r = a ^ b ^ imm;
        endcase
        return {j, t, r};
    endfunction

    assign {bus.alu_jump_in, bus.alu_target_in, bus.alu_result_in} =
        alu_fn(bus.alu_op_out, bus.alu_V1_out, bus.alu_V2_out, bus.alu_imm_out, bus.alu_pc_out);

    // Reference state: pending instruction table plus the two output stages.
    m_ent_t      m [16];
    op_enum_t    e_op;
    logic [31:0] e_v1, e_v2, e_imm, e_pc;
    logic [3:0]  e_rob;
    logic        e_rvalid;
    logic [3:0]  e_rrob;
    logic [31:0] e_rval, e_rtgt;
    logic        e_rjmp;

    function automatic logic [32:0] wake(bit p, logic [3:0] t, logic [31:0] v);
        if (p && bus.cdb_alu_valid_in && bus.cdb_alu_tag_in == t) return {1'b0, bus.cdb_alu_value_in};
        if (p && bus.cdb_lsb_valid_in && bus.cdb_lsb_tag_in == t) return {1'b0, bus.cdb_lsb_value_in};
        return {p, v};
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < 16; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
        e_op = OP_ENUM_RESET;
        e_v1 = '0; e_v2 = '0; e_imm = '0; e_pc = '0; e_rob = '0;
        e_rvalid = 1'b0; e_rrob = '0; e_rval = '0; e_rtgt = '0; e_rjmp = 1'b0;
    endtask

    // One clock of the reference, using the inputs present at that edge.
    task automatic model_step();
        int d;
        int f;
        logic [64:0] r;
        if (!rdy) return;
        if (clr) begin
            for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
            e_op = OP_ENUM_RESET;
            e_rvalid = 1'b0;
            return;
        end
        r = alu_fn(e_op, e_v1, e_v2, e_imm, e_pc);
        e_rvalid = (e_op != OP_ENUM_RESET);
        e_rrob = e_rob;
        {e_rjmp, e_rtgt, e_rval} = r;
        d = -1;
        f = -1;
        for (int i = 0; i < 16; i++) begin
            if (d < 0 && m[i].busy && !m[i].p1 && !m[i].p2) d = i;
            if (f < 0 && !m[i].busy) f = i;
        end
        if (d >= 0) begin
            e_op = m[d].op; e_v1 = m[d].v1; e_v2 = m[d].v2;
            e_imm = m[d].imm; e_pc = m[d].pc; e_rob = m[d].rob;
            m[d].busy = 1'b0;
        end else begin
            e_op = OP_ENUM_RESET;
        end
        for (int i = 0; i < 16; i++) begin
            if (m[i].busy) begin
                {m[i].p1, m[i].v1} = wake(m[i].p1, m[i].t1, m[i].v1);
                {m[i].p2, m[i].v2} = wake(m[i].p2, m[i].t2, m[i].v2);
            end
        end
        if (bus.issue_valid_in && f >= 0) begin
            m[f].busy = 1'b1;
            m[f].op = bus.issue_op_in;
            m[f].t1 = bus.issue_Q1_in;
            m[f].t2 = bus.issue_Q2_in;
            {m[f].p1, m[f].v1} = wake(bus.issue_Q1_valid_in, bus.issue_Q1_in, bus.issue_V1_in);
            {m[f].p2, m[f].v2} = wake(bus.issue_Q2_valid_in, bus.issue_Q2_in, bus.issue_V2_in);
            m[f].imm = bus.issue_imm_in;
            m[f].pc = bus.issue_pc_in;
            m[f].rob = bus.issue_rob_in;
        end
    endtask

    // Operand fields only matter when an op is present; result fields only when valid.
    function automatic snap_t pack(op_enum_t op, logic [31:0] v1, logic [31:0] v2, logic [31:0] imm,
                                   logic [31:0] pc, logic rv, logic [3:0] rrob, logic [31:0] rval,
                                   logic [31:0] rtgt, logic rjmp, logic full);
        if (op == OP_ENUM_RESET) begin v1 = '0; v2 = '0; imm = '0; pc = '0; end
        if (!rv) begin rrob = '0; rval = '0; rtgt = '0; rjmp = 1'b0; end
        return {op, v1, v2, imm, pc, rv, rrob, rval, rtgt, rjmp, full};
    endfunction

    function automatic snap_t dsnap();
        return pack(bus.alu_op_out, bus.alu_V1_out, bus.alu_V2_out, bus.alu_imm_out, bus.alu_pc_out,
                    bus.result_valid_out, bus.result_rob_out, bus.result_value_out,
                    bus.result_target_out, bus.result_jump_out, bus.full_out);
    endfunction

    function automatic snap_t msnap();
        return pack(e_op, e_v1, e_v2, e_imm, e_pc, e_rvalid, e_rrob, e_rval, e_rtgt, e_rjmp,
                    model_full());
    endfunction

    task automatic idle_inputs();
        bus.issue_valid_in = 1'b0;
        bus.cdb_alu_valid_in = 1'b0;
        bus.cdb_lsb_valid_in = 1'b0;
        clr = 1'b0;
        rdy = 1'b1;
    endtask

    task automatic set_issue(op_enum_t op, logic [31:0] v1, bit q1v, logic [3:0] q1,
                             logic [31:0] v2, bit q2v, logic [3:0] q2, logic [3:0] rob);
        bus.issue_valid_in = 1'b1;
        bus.issue_op_in = op;
        bus.issue_V1_in = v1;
        bus.issue_Q1_valid_in = q1v;
        bus.issue_Q1_in = q1;
        bus.issue_V2_in = v2;
        bus.issue_Q2_valid_in = q2v;
        bus.issue_Q2_in = q2;
        bus.issue_imm_in = $urandom;
        bus.issue_pc_in = $urandom & 32'hFFFF_FFFC;
        bus.issue_rob_in = rob;
    endtask

    // Inputs are set at the falling edge; the reference follows the rising edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.issue_op_in = OP_ADD;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.alu_op_out !== OP_ENUM_RESET || bus.full_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_op_full: op=%0d full=%b, want op=0 full=0", bus.alu_op_out, bus.full_out);
        end
        tests++;
        if ({bus.alu_V1_out, bus.alu_V2_out, bus.alu_imm_out, bus.alu_pc_out} !== 128'd0) begin
            fails++;
            $display("FAIL reset_alu_data: v1=%h v2=%h imm=%h pc=%h, want all 0",
                     bus.alu_V1_out, bus.alu_V2_out, bus.alu_imm_out, bus.alu_pc_out);
        end
        tests++;
        if ({bus.result_valid_out, bus.result_rob_out, bus.result_value_out,
             bus.result_target_out, bus.result_jump_out} !== 70'd0) begin
            fails++;
            $display("FAIL reset_result: valid=%b rob=%h value=%h target=%h jump=%b, want all 0",
                     bus.result_valid_out, bus.result_rob_out, bus.result_value_out,
                     bus.result_target_out, bus.result_jump_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_add_latency();
        set_issue(OP_ADD, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'hA);
        tick();
        tests++;
        if (bus.alu_op_out !== OP_ENUM_RESET) begin
            fails++;
            $display("FAIL add_issue_edge: op=%0d, want 0", bus.alu_op_out);
        end
        tick();
        tests++;
        if (bus.alu_op_out !== OP_ADD || bus.alu_V1_out !== 32'd5 || bus.alu_V2_out !== 32'd7) begin
            fails++;
            $display("FAIL add_dispatch: op=%0d v1=%0d v2=%0d, want op=%0d v1=5 v2=7",
                     bus.alu_op_out, bus.alu_V1_out, bus.alu_V2_out, OP_ADD);
        end
        tick();
        tests++;
        if (bus.result_valid_out !== 1'b1 || bus.result_value_out !== 32'd12 || bus.result_rob_out !== 4'hA) begin
            fails++;
            $display("FAIL add_result: valid=%b value=%0d rob=%h, want 1 12 a",
                     bus.result_valid_out, bus.result_value_out, bus.result_rob_out);
        end
    endtask

    task automatic test_wakeup_lsb();
        set_issue(OP_ADD, 32'hDEAD, 1'b1, 4'd3, 32'd1, 1'b0, 4'd0, 4'd5);
        tick();
        for (int c = 1; c <= 3; c++) begin
            tick();
            tests++;
            if (bus.alu_op_out !== OP_ENUM_RESET) begin
                fails++;
                $display("FAIL wake_pending_c%0d: op=%0d, want 0", c, bus.alu_op_out);
            end
        end
        bus.cdb_lsb_valid_in = 1'b1;
        bus.cdb_lsb_tag_in = 4'd3;
        bus.cdb_lsb_value_in = 32'h10;
        tick();
        tests++;
        if (bus.alu_op_out !== OP_ENUM_RESET) begin
            fails++;
            $display("FAIL wake_same_edge: op=%0d, want 0", bus.alu_op_out);
        end
        tick();
        tests++;
        if (bus.alu_op_out !== OP_ADD || bus.alu_V1_out !== 32'h10) begin
            fails++;
            $display("FAIL wake_dispatch: op=%0d v1=%h, want %0d 10", bus.alu_op_out, bus.alu_V1_out, OP_ADD);
        end
        tick();
        tests++;
        if (bus.result_valid_out !== 1'b1 || bus.result_value_out !== 32'h11 || bus.result_rob_out !== 4'd5) begin
            fails++;
            $display("FAIL wake_result: valid=%b value=%h rob=%h, want 1 11 5",
                     bus.result_valid_out, bus.result_value_out, bus.result_rob_out);
        end
    endtask

    task automatic test_issue_cdb_bypass();
        set_issue(OP_SUB, 32'd20, 1'b0, 4'd0, 32'hBAD, 1'b1, 4'd5, 4'd6);
        bus.cdb_alu_valid_in = 1'b1;
        bus.cdb_alu_tag_in = 4'd5;
        bus.cdb_alu_value_in = 32'd9;
        tick();
        tick();
        tests++;
        if (bus.alu_op_out !== OP_SUB || bus.alu_V2_out !== 32'd9) begin
            fails++;
            $display("FAIL bypass_dispatch: op=%0d v2=%0d, want %0d 9", bus.alu_op_out, bus.alu_V2_out, OP_SUB);
        end
        tick();
        tests++;
        if (bus.result_valid_out !== 1'b1 || bus.result_value_out !== 32'd11 || bus.result_rob_out !== 4'd6) begin
            fails++;
            $display("FAIL bypass_result: valid=%b value=%0d rob=%h, want 1 11 6",
                     bus.result_valid_out, bus.result_value_out, bus.result_rob_out);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            set_issue(OP_XOR, 32'd0, 1'b1, 4'(i), 32'(i), 1'b0, 4'd0, 4'(i));
            tick();
        end
        tests++;
        if (bus.full_out !== 1'b1 || dsnap() !== msnap()) begin
            fails++;
            $display("FAIL full_set: full=%b, want 1; dut=%h model=%h", bus.full_out, dsnap(), msnap());
        end
        bus.cdb_alu_valid_in = 1'b1;
        bus.cdb_alu_tag_in = 4'd6;
        bus.cdb_alu_value_in = 32'h55;
        tick();
        tests++;
        if (bus.full_out !== 1'b1) begin
            fails++;
            $display("FAIL full_after_wake: full=%b, want 1", bus.full_out);
        end
        tick();
        tests++;
        if (bus.full_out !== 1'b0 || bus.alu_op_out !== OP_XOR || bus.alu_V1_out !== 32'h55 ||
            bus.alu_V2_out !== 32'd6) begin
            fails++;
            $display("FAIL full_release: full=%b op=%0d v1=%h v2=%0d, want 0 %0d 55 6",
                     bus.full_out, bus.alu_op_out, bus.alu_V1_out, bus.alu_V2_out, OP_XOR);
        end
        clr = 1'b1;
        tick();
    endtask

    task automatic test_dispatch_order();
        logic [31:0] want [3];
        want[0] = 32'd0; want[1] = 32'd2; want[2] = 32'd7;
        for (int i = 0; i < 8; i++) begin
            set_issue(OP_OR, 32'd0, 1'b1, (i == 0 || i == 2 || i == 7) ? 4'd9 : 4'd10,
                      32'(i), 1'b0, 4'd0, 4'(i));
            tick();
        end
        bus.cdb_lsb_valid_in = 1'b1;
        bus.cdb_lsb_tag_in = 4'd9;
        bus.cdb_lsb_value_in = 32'h99;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (bus.alu_op_out !== OP_OR || bus.alu_V2_out !== want[k] || bus.alu_V1_out !== 32'h99) begin
                fails++;
                $display("FAIL order_%0d: op=%0d slot=%0d v1=%h, want %0d %0d 99",
                         k, bus.alu_op_out, bus.alu_V2_out, bus.alu_V1_out, OP_OR, want[k]);
            end
        end
        clr = 1'b1;
        tick();
    endtask

    task automatic test_clear_rdy();
        for (int i = 0; i < 5; i++) begin
            set_issue(OP_AND, 32'd0, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 4'(i));
            tick();
        end
        set_issue(OP_ADD, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd7);
        tick();
        tick();
        clr = 1'b1;
        set_issue(OP_ADD, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd1);
        bus.cdb_alu_valid_in = 1'b1;
        bus.cdb_alu_tag_in = 4'd12;
        bus.cdb_alu_value_in = 32'd1;
        tick();
        tests++;
        if (bus.full_out !== 1'b0 || bus.alu_op_out !== OP_ENUM_RESET || bus.result_valid_out !== 1'b0) begin
            fails++;
            $display("FAIL clear_flush: full=%b op=%0d rvalid=%b, want 0 0 0",
                     bus.full_out, bus.alu_op_out, bus.result_valid_out);
        end
        bus.cdb_lsb_valid_in = 1'b1;
        bus.cdb_lsb_tag_in = 4'd12;
        bus.cdb_lsb_value_in = 32'd2;
        tick();
        tick();
        tests++;
        if (bus.alu_op_out !== OP_ENUM_RESET || bus.result_valid_out !== 1'b0) begin
            fails++;
            $display("FAIL clear_empty: op=%0d rvalid=%b, want 0 0", bus.alu_op_out, bus.result_valid_out);
        end
        set_issue(OP_ADD, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd3);
        tick();
        tick();
        for (int c = 0; c < 3; c++) begin
            rdy = 1'b0;
            set_issue(OP_SUB, $urandom, 1'b0, 4'd0, $urandom, 1'b0, 4'd0, 4'd9);
            bus.cdb_alu_valid_in = 1'b1;
            bus.cdb_alu_tag_in = 4'(c);
            tick();
            tests++;
            if (bus.alu_op_out !== OP_ADD || bus.alu_V1_out !== 32'd1 || bus.result_valid_out !== 1'b0) begin
                fails++;
                $display("FAIL rdy_hold_%0d: op=%0d v1=%0d rvalid=%b, want %0d 1 0",
                         c, bus.alu_op_out, bus.alu_V1_out, bus.result_valid_out, OP_ADD);
            end
        end
        tick();
        tests++;
        if (bus.result_valid_out !== 1'b1 || bus.result_value_out !== 32'd3 || bus.result_rob_out !== 4'd3 ||
            bus.alu_op_out !== OP_ENUM_RESET) begin
            fails++;
            $display("FAIL rdy_resume: rvalid=%b value=%0d rob=%0d op=%0d, want 1 3 3 0",
                     bus.result_valid_out, bus.result_value_out, bus.result_rob_out, bus.alu_op_out);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rdy = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 59) == 0);
            if (!model_full() && $urandom_range(0, 1) == 1)
                set_issue(op_enum_t'(5'($urandom_range(1, 21))), $urandom, 1'($urandom_range(0, 1)),
                          4'($urandom), $urandom, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
            bus.cdb_alu_valid_in = ($urandom_range(0, 4) < 2);
            bus.cdb_alu_tag_in = 4'($urandom);
            bus.cdb_alu_value_in = $urandom;
            bus.cdb_lsb_valid_in = ($urandom_range(0, 4) < 2);
            bus.cdb_lsb_tag_in = 4'($urandom);
            bus.cdb_lsb_value_in = $urandom;
            tick();
            tests++;
            if (dsnap() !== msnap()) begin
                fails++;
                $display("FAIL random_c%0d: dut=%h model=%h", c, dsnap(), msnap());
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_wakeup_lsb();
        test_issue_cdb_bypass();
        test_full();
        test_dispatch_order();
        test_clear_rdy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
